// File: rtl/multiword_add_sequencer.sv
// Streams WORDS x N-bit operand words (LSW first) through an external N-bit adder,
// carrying between words. Optional out_ovf port enabled by OVERFLOW_DETECT_EN.
module multiword_add_sequencer #(
    parameter  int N     = 4,
    parameter  int WORDS = 4,
    localparam int CNT_W = $clog2(WORDS) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         cin,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_cin,
    input  logic [N-1:0] add_sum,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_last,
    output logic         out_cout,
`ifdef OVERFLOW_DETECT_EN
    output logic         out_ovf,
`endif
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             last_word;
    logic             release_done;

    assign last_word = (cnt_q == CNT_W'(WORDS - 1));

    // Valid/ready: a word moves on a rising edge where valid && ready are both high;
    // the output register accepts a new word in the same cycle its old one drains.
    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        busy         = 1'b0;
        add_a        = '0;
        add_b        = '0;
        add_cin      = 1'b0;
        accept       = 1'b0;
        release_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                add_a    = in_a;
                add_b    = in_b;
                add_cin  = carry_q;
                in_ready = !out_valid || out_ready;
                accept   = in_valid && in_ready;
                if (accept && last_word) state_d = DONE;
            end
            DONE: begin
                busy         = 1'b1;
                release_done = out_valid && out_ready && out_last;
                if (release_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
            out_ovf   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                carry_q <= cin;
                cnt_q   <= '0;
            end
            if (accept) begin
                out_sum   <= add_sum;
                out_valid <= 1'b1;
                carry_q   <= add_cout;
                cnt_q     <= cnt_q + CNT_W'(1);
                out_last  <= last_word;
                out_cout  <= last_word ? add_cout : 1'b0;
`ifdef OVERFLOW_DETECT_EN
                // Sign of the top word decides two's-complement overflow of the whole add.
                out_ovf   <= last_word && (in_a[N-1] == in_b[N-1]) && (add_sum[N-1] != in_a[N-1]);
`endif
            end else if (state_q == RUN && out_ready) begin
                out_valid <= 1'b0;
            end
            if (release_done) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                out_cout  <= 1'b0;
                carry_q   <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
                out_ovf   <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer with a behavioural N-bit adder and a
// scoreboard queue of expected {ovf, last, cout, sum} result words.
module tb_multiword_add_sequencer;

    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int TW    = N * WORDS;
    localparam int EW    = N + 3;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         cin;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_cin;
    logic [N-1:0] add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_last;
    logic         out_cout;
    logic         ovf_obs;
    logic         busy;

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

`ifdef OVERFLOW_DETECT_EN
    logic out_ovf;
    assign ovf_obs = out_ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    multiword_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cin(cin),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_last(out_last), .out_cout(out_cout),
`ifdef OVERFLOW_DETECT_EN
        .out_ovf(out_ovf),
`endif
        .busy(busy)
    );

    // External combinational adder the sequencer drives.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a transfer happens at the next rising edge when valid && ready at negedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            chk("out_expected_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                chk("out_word", 32'({ovf_obs, out_last, out_cout, out_sum}), 32'(exp_q.pop_front()));
        end
    end

    task automatic push_expected(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic c);
        logic [TW:0] full;
        logic        ovf;
        full = {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, c};
        ovf  = 1'b0;
`ifdef OVERFLOW_DETECT_EN
        ovf = (a[TW-1] == b[TW-1]) && (full[TW-1] != a[TW-1]);
`endif
        for (int w = 0; w < WORDS; w++) begin
            if (w == WORDS - 1)
                exp_q.push_back({ovf, 1'b1, full[TW], full[w*N +: N]});
            else
                exp_q.push_back({1'b0, 1'b0, 1'b0, full[w*N +: N]});
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_sum"},   32'(out_sum),   32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
        chk({tag, "_out_cout"},  32'(out_cout),  32'd0);
        chk({tag, "_ovf"},       32'(ovf_obs),   32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_add_a"},     32'(add_a),     32'd0);
    endtask

    task automatic do_start(input logic c);
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("idle_before_start", 32'(busy), 32'd0);
        start = 1'b1;
        cin   = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        cin   = 1'b0;
    endtask

    // Driver: one full operation. stall_word/restart_word < 0 disables that disturbance.
    task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic c,
                          input int stall_word, input int restart_word, input bit check_lat);
        int k;
        int first_acc;
        int last_acc;
        logic [N-1:0] held;
        first_acc = 0;
        last_acc  = 0;
        push_expected(a, b, c);
        do_start(c);
        for (int w = 0; w < WORDS; w++) begin
            in_valid = 1'b1;
            in_a     = a[w*N +: N];
            in_b     = b[w*N +: N];
            if (w == restart_word) begin
                start = 1'b1;
                cin   = 1'b1;
            end
            k = 0;
            @(negedge clk);
            while (!in_ready && k < 100) begin
                k++;
                @(negedge clk);
            end
            chk("in_ready_timeout", 32'(k < 100), 32'd1);
            if (w == 0) first_acc = cyc;
            last_acc = cyc;
            @(posedge clk);
            #1;
            start = 1'b0;
            cin   = 1'b0;
            if (check_lat && w == WORDS - 1)
                chk("last_latency", 32'({out_valid, out_last}), 32'b11);
            if (w == stall_word) begin
                out_ready = 1'b0;
                held      = out_sum;
                in_valid  = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    chk("stall_out_valid", 32'(out_valid), 32'd1);
                    chk("stall_out_sum", 32'(out_sum), 32'(held));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (check_lat) chk("throughput", 32'(last_acc - first_acc), 32'(WORDS - 1));
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("back_to_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [TW-1:0] ra;
        logic [TW-1:0] rb;
        rst_n     = 1'b0;
        start     = 1'b0;
        cin       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // Carry propagation across all words.
        run_op(16'h0FFF, 16'h0001, 1'b0, -1, -1, 1'b1);
        // Wrap-around with carry in.
        run_op(16'hFFFF, 16'h0000, 1'b1, -1, -1, 1'b1);
        // Backpressure after the first word.
        ra = 16'($urandom_range(0, 16'hFFFF));
        rb = 16'($urandom_range(0, 16'hFFFF));
        run_op(ra, rb, 1'($urandom_range(0, 1)), 0, -1, 1'b0);
        // start with cin=1 while running must be ignored.
        run_op(16'h0FFF, 16'h0001, 1'b0, -1, 1, 1'b0);
        // Signed-overflow boundary cases.
        run_op(16'h7FFF, 16'h0001, 1'b0, -1, -1, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, -1, -1, 1'b0);
        // Random operands, one with a stall mid-operation.
        for (int r = 0; r < 3; r++) begin
            ra = 16'($urandom_range(0, 16'hFFFF));
            rb = 16'($urandom_range(0, 16'hFFFF));
            run_op(ra, rb, 1'($urandom_range(0, 1)), (r == 1) ? 1 : -1, -1, 1'b0);
        end

        // Reset in the middle of an operation discards the partial result.
        exp_q.push_back({1'b0, 1'b0, 1'b0, 4'hF});
        exp_q.push_back({1'b0, 1'b0, 1'b0, 4'hF});
        do_start(1'b0);
        for (int w = 0; w < 2; w++) begin
            in_valid = 1'b1;
            in_a     = 4'hF;
            in_b     = 4'h0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrun_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_idle("midrun_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("after_reset_idle");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
Upstream/downstream control stage for the team's combinational ripple_carry_adder (N-bit, a/b/cin in, sum/cout out).
- Performs a WORDS×N-bit addition by streaming N-bit operand words, least-significant word first, through one external N-bit adder instance.
- Holds the inter-word carry in a register and returns sum words on a registered valid/ready output.
- Sits between an operand source, such as a register file or FIFO, and a result sink.

Parameters:
N, 4, word width; must equal the N of the attached ripple_carry_adder
WORDS, 4, words per operation (≥1); total operand width is N*WORDS
CNT_W, $clog2(WORDS)+1, word-counter width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin operation; honoured only in IDLE
cin  input  1  initial carry; sampled on accepted start
in_valid  input  1  operand word pair valid
in_ready  output  1  sequencer accepts operand pair this cycle
in_a  input  N  operand A word
in_b  input  N  operand B word
add_a  output  N  to adder .a
add_b  output  N  to adder .b
add_cin  output  1  to adder .cin
add_sum  input  N  from adder .sum
add_cout  input  1  from adder .cout
out_valid  output  1  result word valid
out_ready  input  1  sink accepts result word
out_sum  output  N  result word
out_last  output  1  marks final word of operation
out_cout  output  1  final carry; meaningful only when out_last=1, else 0
busy  output  1  high in RUN and DONE

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, carry_reg=0, word_cnt=0. All outputs are 0: out_valid, out_sum, out_last, out_cout, busy, in_ready.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 → RUN, carry_reg<=cin, word_cnt<=0.
- RUN:
  - add_a=in_a, add_b=in_b, add_cin=carry_reg. These are combinational; the adder path is single-cycle.
  - in_ready = !out_valid || out_ready.
  - An accept is in_valid && in_ready. On an accept:
    - out_sum<=add_sum, out_valid<=1, carry_reg<=add_cout, word_cnt<=word_cnt+1.
    - out_last<=(word_cnt==WORDS-1).
    - out_cout<= add_cout if last word, else 0.
  - Last word accepted → DONE.
- DONE:
  - in_ready=0.
  - When out_valid && out_ready && out_last → IDLE, out_valid<=0, out_last<=0, out_cout<=0, carry_reg<=0.
- Outside RUN: add_a=0, add_b=0, add_cin=0.
- Output register:
  - Single entry; out_valid clears on out_ready when no new accept occurs in the same cycle.
  - Simultaneous consume and accept: the new word replaces the old, and out_valid stays 1.
  - out_sum, out_last and out_cout are held stable while out_valid && !out_ready.
- Latency: 1 cycle from input accept to out_valid. Throughput is 1 word/cycle with out_ready=1.
- Operation time: WORDS cycles minimum from first accept to last out_valid. The next start may be accepted the cycle after returning to IDLE.
- start in RUN/DONE: ignored; no state change and no carry reload.
- WORDS=1: first accept is also last; out_last=1.
- word_cnt resets to 0 on each accepted start; it never wraps mid-operation.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. The partial result is discarded; no out_last is produced.

Optional Feature:
Macro OVERFLOW_DETECT_EN.
- Defined:
  - Adds output out_ovf (1 bit), the two's-complement overflow of the full-width add.
  - On the last-word accept, out_ovf <= (in_a[N-1]==in_b[N-1]) && (add_sum[N-1]!=in_a[N-1]).
  - Else out_ovf<=0. It is held with out_last and cleared on reset and on DONE→IDLE.
- Undefined: no out_ovf port and no extra logic; behaviour otherwise identical.

Test Plan:
- Reset, then check idle state: rst_n=0 mid-run, then 1 → all outputs 0, in_ready=0, busy=0 with no start.
- Carry propagation: N=4, WORDS=4, cin=0, A=0x0FFF, B=0x0001, words fed LSW-first with out_ready=1 → out_sum sequence 0x0,0x0,0x0,0x1; out_last on 4th word; out_cout=0; 4 cycles first accept→last valid.
- Wrap-around: A=0xFFFF, B=0x0000, cin=1 → out_sum 0x0,0x0,0x0,0x0; out_cout=1.
- Backpressure: out_ready=0 after first word → in_ready=0 while out_valid=1; out_sum stable for 5 cycles. Release → remaining words are correct with no drop or duplicate.
- Start while busy: pulse start with cin=1 during RUN after word 1 → ignored; result still 0x1000 for the carry-propagation operands.
- OVERFLOW_DETECT_EN:
  - A=0x7FFF, B=0x0001 → out_sum 0x8000, out_ovf=1 with out_last.
  - A=0xFFFF, B=0x0001 → out_ovf=0.
